// File: rtl/mem_pkg.sv
// mem_pkg: shared constants, state and requester encodings for the memory arbiter
package mem_pkg;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int AGE_LIMIT = 4;
  localparam logic [3:0] FULL_BE = 4'b1111;
  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, ACK = 2'b10} state_t;
  typedef enum logic [1:0] {WB = 2'd0, D = 2'd1, I = 2'd2} rid_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: main-memory port between the arbiter (master) and memory (slave)
interface mem_arbiter_if;
  import mem_pkg::*;
  logic [AW-1:0] adr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic [3:0] byteen;
  logic rwb;
  logic en;
  logic done;
  modport master(output adr, wdata, byteen, rwb, en, input rdata, done);
  modport slave(input adr, wdata, byteen, rwb, en, output rdata, done);
endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: fixed-priority one-hot grant, aged reads jump above the write buffer
module mem_arb_pick
  import mem_pkg::*;
(
  input  logic wb_req,
  input  logic d_req,
  input  logic i_req,
  input  logic swc,
  input  logic d_aged,
  input  logic i_aged,
  output logic [2:0] gnt
);
  logic ad, ai;
  assign ad = d_req & d_aged;
  assign ai = i_req & i_aged;
  // aged reads first, then writes, then reads in swc order
  always_comb
    gnt = (ad | ai) ? {ai & (swc | ~ad), ad & (~swc | ~ai), 1'b0} :
          wb_req    ? 3'b001 :
                      {i_req & (swc | ~d_req), d_req & (~swc | ~i_req), 1'b0};
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port among write buffer, dcache and icache refills (age promotion under MEM_ARB_AGE_EN)
module mem_arbiter
  import mem_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic swc,
  input  logic wb_req,
  input  logic [AW-1:0] wb_adr,
  input  logic [DW-1:0] wb_wdata,
  input  logic [3:0] wb_byteen,
  output logic wb_ack,
  input  logic d_req,
  input  logic [AW-1:0] d_adr,
  output logic d_ack,
  input  logic i_req,
  input  logic [AW-1:0] i_adr,
  output logic i_ack,
  output logic [DW-1:0] d_rdata,
  output logic [DW-1:0] i_rdata,
  output logic busy,
  mem_arbiter_if.master mem
);
  state_t state;
  rid_t owner;
  logic [DW-1:0] rdata;
  logic [2:0] gnt;
  logic d_aged, i_aged;
  assign d_rdata = rdata;
  assign i_rdata = rdata;
  assign busy = state != IDLE;
  mem_arb_pick u_pick (
    .wb_req(wb_req),
    .d_req(d_req),
    .i_req(i_req),
    .swc(swc),
    .d_aged(d_aged),
    .i_aged(i_aged),
    .gnt(gnt)
  );
`ifdef MEM_ARB_AGE_EN
  logic [2:0] d_age, i_age;
  // a read that loses an IDLE decision ages by one (saturating); its grant clears it
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      d_age <= '0;
      i_age <= '0;
    end else if (state == IDLE && |gnt) begin
      d_age <= gnt[D] ? '0 : (d_req && d_age != 3'd7) ? d_age + 3'd1 : d_age;
      i_age <= gnt[I] ? '0 : (i_req && i_age != 3'd7) ? i_age + 3'd1 : i_age;
    end
  assign d_aged = int'(d_age) >= AGE_LIMIT;
  assign i_aged = int'(i_age) >= AGE_LIMIT;
`else
  assign d_aged = 1'b0;
  assign i_aged = 1'b0;
`endif
  // IDLE grants and registers the winner, BUSY waits for memory, ACK pulses the winner's ack
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      owner <= WB;
      rdata <= '0;
      wb_ack <= 1'b0;
      d_ack <= 1'b0;
      i_ack <= 1'b0;
      mem.en <= 1'b0;
      mem.rwb <= 1'b1;
      mem.adr <= '0;
      mem.wdata <= '0;
      mem.byteen <= '0;
    end else begin
      case (state)
        IDLE: if (|gnt) begin
          owner <= gnt[I] ? I : gnt[D] ? D : WB;
          mem.adr <= gnt[I] ? i_adr : gnt[D] ? d_adr : wb_adr;
          mem.wdata <= gnt[WB] ? wb_wdata : mem.wdata;
          mem.byteen <= gnt[WB] ? wb_byteen : FULL_BE;
          mem.rwb <= ~gnt[WB];
          mem.en <= 1'b1;
          state <= BUSY;
        end
        BUSY: if (mem.done) begin
          mem.en <= 1'b0;
          rdata <= mem.rwb ? mem.rdata : rdata;
          wb_ack <= owner == WB;
          d_ack <= owner == D;
          i_ack <= owner == I;
          state <= ACK;
        end
        ACK: begin
          wb_ack <= 1'b0;
          d_ack <= 1'b0;
          i_ack <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed table-driven bench for mem_arbiter with a latency-programmable memory model
module tb_mem_arbiter;
  import mem_pkg::*;
  typedef struct {
    bit wb;
    bit d;
    bit i;
    bit s;
    int n;
    rid_t o[3];
  } vec_t;
  logic clk = 0;
  logic reset = 0;
  logic swc = 0;
  logic wb_req = 0, d_req = 0, i_req = 0;
  logic [AW-1:0] wb_adr = 'h4AD, d_adr = 'h4AD, i_adr = 'h2F0;
  logic [DW-1:0] wb_wdata = 32'hDDCCBBAA;
  logic [3:0] wb_byteen = 4'b0011;
  logic wb_ack, d_ack, i_ack, busy;
  logic [DW-1:0] d_rdata, i_rdata;
  logic stray = 0;
  logic [DW-1:0] last_wdata = '0;
  int lat = 1;
  int cnt = 0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  rid_t got[$];
  int when[$];
  vec_t vt[8];
  mem_arbiter_if mem();
  mem_arbiter dut (
    .clk(clk), .reset(reset), .swc(swc),
    .wb_req(wb_req), .wb_adr(wb_adr), .wb_wdata(wb_wdata), .wb_byteen(wb_byteen), .wb_ack(wb_ack),
    .d_req(d_req), .d_adr(d_adr), .d_ack(d_ack),
    .i_req(i_req), .i_adr(i_adr), .i_ack(i_ack),
    .d_rdata(d_rdata), .i_rdata(i_rdata), .busy(busy), .mem(mem)
  );
  function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
    return 32'h21212121 ^ {2'b00, a} ^ 32'h4AD;
  endfunction
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    cnt <= (mem.en && !mem.done) ? cnt + 1 : 0;
  end
  assign mem.done = (mem.en && cnt == lat - 1) || stray;
  assign mem.rdata = rd_model(mem.adr);
  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask
  task automatic collect(input int n, input int budget, input bit keep_wb);
    rid_t id;
    got.delete();
    when.delete();
    for (int c = 0; c < budget && got.size() < n; c++) begin
      @(negedge clk);
      chk("ack_onehot", 32'(int'(wb_ack) + int'(d_ack) + int'(i_ack) <= 1), 1);
      if (mem.en) chk("busy_byteen", mem.byteen, mem.rwb ? FULL_BE : wb_byteen);
      if (wb_ack || d_ack || i_ack) begin
        id = wb_ack ? WB : d_ack ? D : I;
        got.push_back(id);
        when.push_back(cyc);
        chk("busy_in_ack", busy, 1);
        chk("en_low_in_ack", mem.en, 0);
        chk("ack_adr", mem.adr, id == WB ? wb_adr : id == D ? d_adr : i_adr);
        chk("ack_rwb", mem.rwb, id != WB);
        if (id == WB) begin
          chk("wdata", mem.wdata, wb_wdata);
          last_wdata = wb_wdata;
          if (!keep_wb) wb_req = 0;
        end else begin
          chk("read_wdata_held", mem.wdata, last_wdata);
          chk("rdata", id == D ? d_rdata : i_rdata, rd_model(id == D ? d_adr : i_adr));
          if (id == D) d_req = 0;
          else i_req = 0;
        end
      end
    end
    if (got.size() < n) chk("ack_timeout", got.size(), n);
  endtask
  initial begin
    int start, nd, first_d;
    vt[0] = '{0, 1, 0, 0, 1, '{D, WB, WB}};
    vt[1] = '{0, 0, 1, 0, 1, '{I, WB, WB}};
    vt[2] = '{1, 0, 0, 0, 1, '{WB, WB, WB}};
    vt[3] = '{1, 1, 1, 0, 3, '{WB, D, I}};
    vt[4] = '{1, 1, 1, 1, 3, '{WB, I, D}};
    vt[5] = '{0, 1, 1, 0, 2, '{D, I, WB}};
    vt[6] = '{0, 1, 1, 1, 2, '{I, D, WB}};
    vt[7] = '{1, 0, 1, 0, 2, '{WB, I, WB}};
    repeat (2) @(negedge clk);
    chk("rst_en", mem.en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_acks", {wb_ack, d_ack, i_ack}, 0);
    chk("rst_rwb", mem.rwb, 1);
    chk("rst_byteen", mem.byteen, 0);
    chk("rst_adr", mem.adr, 0);
    chk("rst_wdata", mem.wdata, 0);
    chk("rst_rdata", d_rdata, 0);
    reset = 1;
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      swc = vt[v].s;
      wb_req = vt[v].wb;
      d_req = vt[v].d;
      i_req = vt[v].i;
      start = cyc;
      collect(vt[v].n, 30, 0);
      chk($sformatf("v%0d_count", v), got.size(), vt[v].n);
      for (int k = 0; k < vt[v].n; k++)
        if (k < got.size()) begin
          chk($sformatf("v%0d_order%0d", v, k), got[k], vt[v].o[k]);
          chk($sformatf("v%0d_time%0d", v, k), when[k] - start, 2 + 3 * k);
        end
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      stray = 1;
      @(negedge clk);
      chk("stray_done_acks", {wb_ack, d_ack, i_ack}, 0);
      chk("stray_done_busy", busy, 0);
    end
    stray = 0;
    @(negedge clk);
    swc = 0;
    wb_req = 1;
    d_req = 1;
`ifdef MEM_ARB_AGE_EN
    collect(5, 40, 1);
`else
    collect(6, 40, 1);
`endif
    nd = 0;
    first_d = -1;
    foreach (got[k]) if (got[k] == D) begin
      nd++;
      if (first_d < 0) first_d = k;
    end
`ifdef MEM_ARB_AGE_EN
    chk("aged_d_position", first_d, 4);
    wb_req = 0;
`else
    chk("no_d_while_wb", nd, 0);
    wb_req = 0;
    collect(1, 20, 0);
    chk("d_after_wb_drop", got.size() > 0 ? got[0] : WB, D);
`endif
    @(negedge clk);
    @(negedge clk);
    lat = 5;
    d_req = 1;
    for (int c = 0; c < 10 && !mem.en; c++) @(negedge clk);
    chk("en_before_reset", mem.en, 1);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 0;
    #1;
    chk("async_rst_en", mem.en, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_rwb", mem.rwb, 1);
    chk("async_rst_adr", mem.adr, 0);
    chk("async_rst_rdata", d_rdata, 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("no_ack_after_abort", {wb_ack, d_ack, i_ack}, 0);
    end
    last_wdata = '0;
    lat = 1;
    reset = 1;
    start = cyc;
    collect(1, 20, 0);
    chk("fresh_d_after_reset", got.size() > 0 ? got[0] : WB, D);
    chk("fresh_d_latency", got.size() > 0 ? when[0] - start : 0, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single main-memory port and shares it among three requesters: write buffer (writes only), data-cache refill (reads), instruction-cache refill (reads).
- Sits between the cache controller's icache/dcache/write-buffer memory sides and main memory.
- Replaces the ad-hoc don/ion/wbon logic with one registered FSM, a fixed-priority grant and a clean req/ack handshake.

Parameters:
- AW, 30, word-address width.
- DW, 32, data width.
- AGE_LIMIT, 4, consecutive lost arbitrations before a waiting read requester is promoted (optional feature only).

Ports:
- clk  in  1  clock, all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- swc  in  1  cache swap: 0 = dcache beats icache, 1 = icache beats dcache.
- wb_req  in  1  write-buffer request; wb_adr in AW; wb_wdata in DW; wb_byteen in 4.
- wb_ack  out  1  one-cycle pulse: write accepted by memory.
- d_req  in  1  dcache read request; d_adr in AW.
- d_ack  out  1  one-cycle pulse: d_rdata valid.
- i_req  in  1  icache read request; i_adr in AW.
- i_ack  out  1  one-cycle pulse: i_rdata valid.
- d_rdata, i_rdata  out  DW  latched read data; both driven from one shared register.
- mem_adr  out  AW  memory address; mem_wdata out DW; mem_byteen out 4.
- mem_rwb  out  1  1 = read, 0 = write.
- mem_en  out  1  request to memory; held until mem_done.
- mem_rdata  in  DW  memory read data, valid while mem_done is high.
- mem_done  in  1  memory completion, sampled only in BUSY.
- busy  out  1  high in BUSY or ACK.

Behaviour:
- Reset, asynchronous, any state, including mid-transaction:
  - State IDLE.
  - mem_en, all acks, busy = 0.
  - mem_adr, mem_wdata, rdata register = 0; mem_byteen = 0; mem_rwb = 1.
  - Age counters = 0.
  - An abandoned memory transaction is not resumed.
- FSM states:
  - IDLE:
    - If any req is high, register the winner's adr, wdata, byteen and rwb.
    - Set mem_en = 1 and go to BUSY.
    - If no req is high, stay in IDLE.
  - BUSY:
    - Outputs are held stable.
    - On mem_done = 1: mem_en <= 0, rdata <= mem_rdata (reads only), winner's ack <= 1, go to ACK.
  - ACK:
    - Ack deasserts next edge; go to IDLE.
    - Requests are not sampled in ACK; this turnaround cycle lets the requester drop req.
- Priority, fixed: wb > (swc ? i : d) > (swc ? d : i). Pending writes always drain first.
- Read byteen: mem_byteen = 4'b1111; mem_wdata is held at its previous value.
- Latency:
  - req sampled in IDLE at edge N → mem_en high after N.
  - mem_done sampled at edge M → ack high for exactly the cycle after M.
  - Minimum req-to-ack is 2 edges when memory completes in one cycle; back-to-back grants are 3 cycles apart.
- Handshake rules:
  - A requester holds req, adr and data stable until its ack.
  - Dropping req before ack does not abort the transaction.
  - Exactly one ack is asserted per transaction; acks are never simultaneous.
- swc changes only affect the next IDLE decision, never a granted transaction.
- mem_done high while in IDLE or ACK is ignored.

Optional Feature:
- Macro: MEM_ARB_AGE_EN.
- With the macro defined:
  - Each read requester has a saturating 3-bit age counter, incremented when it requests in IDLE but loses, and cleared when it is granted.
  - A counter at AGE_LIMIT places that requester above wb.
  - If both are aged, the normal swc order applies.
- Without the macro: no counters; pure fixed priority; wb can starve reads indefinitely.

Decomposition:
- Shared package mem_pkg:
  - AW/DW constants.
  - State encoding: IDLE = 2'b00, BUSY = 2'b01, ACK = 2'b10.
  - Requester-id encoding: WB = 0, D = 1, I = 2.
  - Full-word byteen constant.
- One natural sub-module, mem_arb_pick: combinational priority selector taking the three reqs, swc and the age flags, returning a one-hot grant.
- The FSM and registers remain in mem_arbiter.

Test Plan:
- Single dcache read, d_adr = 'h4AD, memory returns 'h21212121 one cycle after mem_en → mem_rwb = 1, mem_byteen = 4'b1111, d_ack pulse one cycle, d_rdata = 'h21212121, i_ack/wb_ack stay 0.
- wb, d and i request together, swc = 0 → grant order wb, d, i; mem_en never drops for fewer than one cycle between them; acks 3 cycles apart at 1-cycle memory.
- Same requests with swc = 1 → order wb, i, d.
- wb write adr = 'h4AD, wdata = 'hDDCCBBAA, byteen = 4'b0011 → mem_rwb = 0, mem_byteen = 4'b0011 for the whole BUSY, wb_ack after mem_done.
- reset pulled low during BUSY with 5-cycle memory → mem_en = 0 immediately (asynchronous), no ack ever issued, fresh d_req after release granted normally.
- MEM_ARB_AGE_EN, AGE_LIMIT = 4, wb_req held high continuously with d_req high → d granted on its 5th IDLE decision; without the macro, d is never granted while wb_req stays high.
